// File: rtl/chronospatial_run_ctrl.sv
// chronospatial_run_ctrl
// Run controller for a small 3-bit core. It takes byte commands and uses them
// to load the program memory and the A/B/C initial values. It starts and stops
// the core, and collects the core's outputs into a small FIFO.
//
// Optional feature: define CHRONO_RUN_WATCHDOG_EN to add a 16-bit RUN watchdog.
// When the watchdog expires, the core is forced into DONE with err_code 3.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_data/cmd_ready  command byte: [7:5] opcode, [2:0] payload
//   prog_wr_en/addr/data          program memory write port
//   reg_load, reg_{a,b,c}_init    initial register values, load strobe
//   core_hold                     holds the core idle when high
//   core_halt                     core halt indication
//   core_out_valid/core_reg_out   core output strobe and value
//   out_valid/out_data/out_ready  output FIFO drain handshake
//   busy, done                    state == RUN, state == DONE
//   err_code                      sticky first error (1 cmd, 2 overflow, 3 watchdog)
module chronospatial_run_ctrl #(
   parameter int unsigned REG_W      = 12,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [7:0]       cmd_data,
   output logic             cmd_ready,
   output logic             prog_wr_en,
   output logic [3:0]       prog_wr_addr,
   output logic [2:0]       prog_wr_data,
   output logic             reg_load,
   output logic [REG_W-1:0] reg_a_init,
   output logic [REG_W-1:0] reg_b_init,
   output logic [REG_W-1:0] reg_c_init,
   output logic             core_hold,
   input  logic             core_halt,
   input  logic             core_out_valid,
   input  logic [2:0]       core_reg_out,
   output logic             out_valid,
   output logic [2:0]       out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic [1:0]       err_code
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_PROG  = 3'd1;
   localparam logic [2:0] OP_REGA  = 3'd2;
   localparam logic [2:0] OP_REGB  = 3'd3;
   localparam logic [2:0] OP_REGC  = 3'd4;
   localparam logic [2:0] OP_RUN   = 3'd5;
   localparam logic [2:0] OP_CLEAR = 3'd6;
   localparam logic [2:0] OP_ABORT = 3'd7;

   logic [1:0]       state_q, state_d;
   logic [4:0]       prog_len_q, prog_len_d;
   logic             prog_wr_en_q, prog_wr_en_d;
   logic [3:0]       prog_wr_addr_q, prog_wr_addr_d;
   logic [2:0]       prog_wr_data_q, prog_wr_data_d;
   logic             reg_load_q, reg_load_d;
   logic [REG_W-1:0] reg_a_q, reg_a_d;
   logic [REG_W-1:0] reg_b_q, reg_b_d;
   logic [REG_W-1:0] reg_c_q, reg_c_d;
   logic             core_hold_q, core_hold_d;
   logic [1:0]       err_q, err_d;
   logic [2:0]       mem_q [FIFO_DEPTH];
   logic [2:0]       mem_d [FIFO_DEPTH];
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW-1:0]    wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef CHRONO_RUN_WATCHDOG_EN
   logic [15:0]      wd_q, wd_d;
`endif

   logic [2:0] opcode;
   logic [2:0] payload;
   logic       cmd_unused;
   logic [1:0] err_new;
   logic       err_clr;
   logic       fifo_flush;
   logic       fifo_full;
   logic       fifo_pop;
   logic       fifo_push;

   assign opcode     = cmd_data[7:5];
   assign payload    = cmd_data[2:0];
   assign cmd_unused = ^cmd_data[4:3];

   // Commands are accepted unconditionally in every state.
   assign cmd_ready    = 1'b1;
   assign prog_wr_en   = prog_wr_en_q;
   assign prog_wr_addr = prog_wr_addr_q;
   assign prog_wr_data = prog_wr_data_q;
   assign reg_load     = reg_load_q;
   assign reg_a_init   = reg_a_q;
   assign reg_b_init   = reg_b_q;
   assign reg_c_init   = reg_c_q;
   assign core_hold    = core_hold_q;
   assign busy         = (state_q == ST_RUN);
   assign done         = (state_q == ST_DONE);
   assign err_code     = err_q;
   assign out_valid    = (cnt_q != '0);
   assign out_data     = mem_q[rd_q];

   // Next-state, command decode, FIFO bookkeeping and error capture.
   always_comb begin
      state_d        = state_q;
      prog_len_d     = prog_len_q;
      prog_wr_en_d   = 1'b0;
      prog_wr_addr_d = prog_wr_addr_q;
      prog_wr_data_d = prog_wr_data_q;
      reg_load_d     = 1'b0;
      reg_a_d        = reg_a_q;
      reg_b_d        = reg_b_q;
      reg_c_d        = reg_c_q;
      core_hold_d    = core_hold_q;
      mem_d          = mem_q;
      rd_d           = rd_q;
      wr_d           = wr_q;
      cnt_d          = cnt_q;
      err_new        = 2'd0;
      err_clr        = 1'b0;
      fifo_flush     = 1'b0;
`ifdef CHRONO_RUN_WATCHDOG_EN
      wd_d           = wd_q;
`endif

      // The core leaves hold one cycle after the load strobe.
      if (reg_load_q) core_hold_d = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (cmd_valid && (opcode != OP_NOP) && (opcode != OP_ABORT))
               err_new = 2'd1;
            // ABORT takes priority over a coincident halt.
            if (cmd_valid && (opcode == OP_ABORT)) begin
               core_hold_d = 1'b1;
               state_d     = ST_IDLE;
            end else if (core_halt) begin
               core_hold_d = 1'b1;
               state_d     = ST_DONE;
            end
`ifdef CHRONO_RUN_WATCHDOG_EN
            else if (wd_q == 16'hFFFF) begin
               core_hold_d = 1'b1;
               state_d     = ST_DONE;
               if (err_new == 2'd0) err_new = 2'd3;
            end else begin
               wd_d = wd_q + 16'd1;
            end
`endif
         end
         default: begin
            if (cmd_valid) begin
               case (opcode)
                  OP_PROG: begin
                     // The address never wraps; prog_len saturates at 16.
                     if (prog_len_q < 5'd16) begin
                        prog_wr_en_d   = 1'b1;
                        prog_wr_addr_d = prog_len_q[3:0];
                        prog_wr_data_d = payload;
                        prog_len_d     = prog_len_q + 5'd1;
                     end else begin
                        err_new = 2'd1;
                     end
                  end
                  OP_REGA: reg_a_d = (reg_a_q << 3) | REG_W'(payload);
                  OP_REGB: reg_b_d = (reg_b_q << 3) | REG_W'(payload);
                  OP_REGC: reg_c_d = (reg_c_q << 3) | REG_W'(payload);
                  OP_RUN: begin
                     if (prog_len_q != 5'd0) begin
                        reg_load_d = 1'b1;
                        state_d    = ST_RUN;
                        fifo_flush = 1'b1;
`ifdef CHRONO_RUN_WATCHDOG_EN
                        wd_d       = 16'd0;
`endif
                     end else begin
                        err_new = 2'd1;
                     end
                  end
                  OP_CLEAR: begin
                     prog_len_d = 5'd0;
                     reg_a_d    = '0;
                     reg_b_d    = '0;
                     reg_c_d    = '0;
                     fifo_flush = 1'b1;
                     err_clr    = 1'b1;
                     state_d    = ST_IDLE;
                  end
                  default: ;
               endcase
            end
         end
      endcase

      // Output FIFO: a push into a full FIFO is allowed when a pop frees the slot.
      fifo_full = (cnt_q == CW'(FIFO_DEPTH));
      fifo_pop  = (cnt_q != '0) && out_ready;
      fifo_push = 1'b0;
      if ((state_q == ST_RUN) && core_out_valid) begin
         if (!fifo_full || fifo_pop) fifo_push = 1'b1;
         else if (err_new == 2'd0)   err_new   = 2'd2;
      end

      if (fifo_flush) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (fifo_push) begin
            mem_d[wr_q] = core_reg_out;
            wr_d        = wr_q + AW'(1);
         end
         if (fifo_pop) rd_d = rd_q + AW'(1);
         case ({fifo_push, fifo_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end

      // Only the first nonzero error is kept.
      if (err_clr)             err_d = 2'd0;
      else if (err_q == 2'd0)  err_d = err_new;
      else                     err_d = err_q;
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         prog_len_q     <= 5'd0;
         prog_wr_en_q   <= 1'b0;
         prog_wr_addr_q <= 4'd0;
         prog_wr_data_q <= 3'd0;
         reg_load_q     <= 1'b0;
         reg_a_q        <= '0;
         reg_b_q        <= '0;
         reg_c_q        <= '0;
         core_hold_q    <= 1'b1;
         err_q          <= 2'd0;
         rd_q           <= '0;
         wr_q           <= '0;
         cnt_q          <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 3'd0;
`ifdef CHRONO_RUN_WATCHDOG_EN
         wd_q           <= 16'd0;
`endif
      end else begin
         state_q        <= state_d;
         prog_len_q     <= prog_len_d;
         prog_wr_en_q   <= prog_wr_en_d;
         prog_wr_addr_q <= prog_wr_addr_d;
         prog_wr_data_q <= prog_wr_data_d;
         reg_load_q     <= reg_load_d;
         reg_a_q        <= reg_a_d;
         reg_b_q        <= reg_b_d;
         reg_c_q        <= reg_c_d;
         core_hold_q    <= core_hold_d;
         err_q          <= err_d;
         rd_q           <= rd_d;
         wr_q           <= wr_d;
         cnt_q          <= cnt_d;
         mem_q          <= mem_d;
`ifdef CHRONO_RUN_WATCHDOG_EN
         wd_q           <= wd_d;
`endif
      end
   end

endmodule

// File: tb/tb_chronospatial_run_ctrl.sv
// Directed testbench for chronospatial_run_ctrl (default parameters).
module tb_chronospatial_run_ctrl;

   localparam int unsigned REG_W = 12;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_PROG  = 3'd1;
   localparam logic [2:0] OP_REGA  = 3'd2;
   localparam logic [2:0] OP_REGB  = 3'd3;
   localparam logic [2:0] OP_RUN   = 3'd5;
   localparam logic [2:0] OP_CLEAR = 3'd6;
   localparam logic [2:0] OP_ABORT = 3'd7;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic [7:0]       cmd_data;
   logic             cmd_ready;
   logic             prog_wr_en;
   logic [3:0]       prog_wr_addr;
   logic [2:0]       prog_wr_data;
   logic             reg_load;
   logic [REG_W-1:0] reg_a_init;
   logic [REG_W-1:0] reg_b_init;
   logic [REG_W-1:0] reg_c_init;
   logic             core_hold;
   logic             core_halt;
   logic             core_out_valid;
   logic [2:0]       core_reg_out;
   logic             out_valid;
   logic [2:0]       out_data;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic [1:0]       err_code;

   int checks = 0;
   int errors = 0;

   chronospatial_run_ctrl #(.REG_W(REG_W), .FIFO_DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_data       (cmd_data),
      .cmd_ready      (cmd_ready),
      .prog_wr_en     (prog_wr_en),
      .prog_wr_addr   (prog_wr_addr),
      .prog_wr_data   (prog_wr_data),
      .reg_load       (reg_load),
      .reg_a_init     (reg_a_init),
      .reg_b_init     (reg_b_init),
      .reg_c_init     (reg_c_init),
      .core_hold      (core_hold),
      .core_halt      (core_halt),
      .core_out_valid (core_out_valid),
      .core_reg_out   (core_reg_out),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
      .busy           (busy),
      .done           (done),
      .err_code       (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [2:0] pl);
      cmd_valid = 1'b1;
      cmd_data  = {op, 2'b00, pl};
      step();
      cmd_valid = 1'b0;
      cmd_data  = 8'd0;
   endtask

   task automatic push(input logic [2:0] v);
      core_out_valid = 1'b1;
      core_reg_out   = v;
      step();
      core_out_valid = 1'b0;
   endtask

   initial begin
      logic [2:0] prog_vals [4];
      logic [2:0] drain_vals [4];
      int         cyc;

      prog_vals  = '{3'd2, 3'd4, 3'd1, 3'd5};
      drain_vals = '{3'd2, 3'd3, 3'd4, 3'd5};

      rst = 1'b1; cmd_valid = 1'b0; cmd_data = 8'd0; core_halt = 1'b0;
      core_out_valid = 1'b0; core_reg_out = 3'd0; out_ready = 1'b0;
      step(); step();

      // Reset state
      chk("rst_core_hold", 32'(core_hold), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_err", 32'(err_code), 32'd0);
      chk("rst_prog_wr_en", 32'(prog_wr_en), 32'd0);
      chk("rst_reg_load", 32'(reg_load), 32'd0);
      chk("rst_reg_a", 32'(reg_a_init), 32'd0);
      chk("cmd_ready", 32'(cmd_ready), 32'd1);
      rst = 1'b0;
      step();

      // Program load
      for (int i = 0; i < 4; i++) begin
         send(OP_PROG, prog_vals[i]);
         chk("load_wr_en", 32'(prog_wr_en), 32'd1);
         chk("load_wr_addr", 32'(prog_wr_addr), 32'(i));
         chk("load_wr_data", 32'(prog_wr_data), 32'(prog_vals[i]));
      end
      send(OP_REGA, 3'd1);
      chk("load_wr_en_off", 32'(prog_wr_en), 32'd0);
      send(OP_REGA, 3'd2);
      send(OP_REGA, 3'd3);
      send(OP_REGA, 3'd4);
      chk("reg_a_init", 32'(reg_a_init), 32'h29C);
      send(OP_REGB, 3'd7);
      chk("reg_b_init", 32'(reg_b_init), 32'h007);
      chk("reg_c_init", 32'(reg_c_init), 32'h000);

      // Run, two outputs, halt
      send(OP_RUN, 3'd0);
      chk("run_reg_load", 32'(reg_load), 32'd1);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_hold_n1", 32'(core_hold), 32'd1);
      step();
      chk("run_reg_load_off", 32'(reg_load), 32'd0);
      chk("run_hold_n2", 32'(core_hold), 32'd0);
      push(3'd3);
      push(3'd7);
      chk("run_out_valid", 32'(out_valid), 32'd1);
      chk("run_out_data0", 32'(out_data), 32'd3);
      core_halt = 1'b1;
      step();
      core_halt = 1'b0;
      chk("halt_done", 32'(done), 32'd1);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_hold", 32'(core_hold), 32'd1);
      out_ready = 1'b1;
      step();
      chk("drain_out_data1", 32'(out_data), 32'd7);
      step();
      chk("drain_empty", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      chk("run_err", 32'(err_code), 32'd0);

      // FIFO full, push+pop on full, overflow
      send(OP_RUN, 3'd0);
      step();
      push(3'd1); push(3'd2); push(3'd3); push(3'd4);
      chk("fifo_full_err", 32'(err_code), 32'd0);
      out_ready = 1'b1;
      push(3'd5);
      out_ready = 1'b0;
      chk("fifo_pushpop_err", 32'(err_code), 32'd0);
      chk("fifo_head", 32'(out_data), 32'd2);
      push(3'd6);
      chk("fifo_overflow_err", 32'(err_code), 32'd2);

      // ABORT coinciding with halt
      cmd_valid = 1'b1; cmd_data = {OP_ABORT, 5'd0}; core_halt = 1'b1;
      step();
      cmd_valid = 1'b0; cmd_data = 8'd0; core_halt = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_hold", 32'(core_hold), 32'd1);
      chk("abort_err_kept", 32'(err_code), 32'd2);

      // Drain in IDLE; the dropped 6 must not appear
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("idle_drain_valid", 32'(out_valid), 32'd1);
         chk("idle_drain_data", 32'(out_data), 32'(drain_vals[i]));
         step();
      end
      out_ready = 1'b0;
      chk("idle_drain_empty", 32'(out_valid), 32'd0);

      // CLEAR, then RUN with empty program
      send(OP_CLEAR, 3'd0);
      chk("clear_err", 32'(err_code), 32'd0);
      chk("clear_reg_a", 32'(reg_a_init), 32'd0);
      send(OP_RUN, 3'd0);
      chk("run_empty_busy", 32'(busy), 32'd0);
      chk("run_empty_reg_load", 32'(reg_load), 32'd0);
      chk("run_empty_err", 32'(err_code), 32'd1);

      // Program overflow
      send(OP_CLEAR, 3'd0);
      for (int i = 0; i < 16; i++) begin
         send(OP_PROG, 3'(i));
         chk("ovf_wr_en", 32'(prog_wr_en), 32'd1);
         chk("ovf_wr_addr", 32'(prog_wr_addr), 32'(i));
      end
      chk("ovf_err_before", 32'(err_code), 32'd0);
      send(OP_PROG, 3'd7);
      chk("ovf_17th_wr_en", 32'(prog_wr_en), 32'd0);
      chk("ovf_err", 32'(err_code), 32'd1);

      // Non-NOP command in RUN is dropped; halt outside RUN ignored
      send(OP_CLEAR, 3'd0);
      send(OP_PROG, 3'd1);
      send(OP_RUN, 3'd0);
      step();
      send(OP_REGA, 3'd5);
      chk("run_drop_err", 32'(err_code), 32'd1);
      chk("run_drop_reg_a", 32'(reg_a_init), 32'd0);
      chk("run_drop_busy", 32'(busy), 32'd1);
      send(OP_ABORT, 3'd0);
      chk("abort_idle", 32'(busy), 32'd0);
      send(OP_ABORT, 3'd0);
      chk("abort_nop_done", 32'(done), 32'd0);
      core_halt = 1'b1;
      step();
      core_halt = 1'b0;
      chk("halt_idle_ignored", 32'(done), 32'd0);

      // Long run: watchdog expiry or persistence
      send(OP_CLEAR, 3'd0);
      send(OP_PROG, 3'd2);
      send(OP_NOP, 3'd0);
      send(OP_RUN, 3'd0);
`ifdef CHRONO_RUN_WATCHDOG_EN
      cyc = 0;
      while (!done && cyc < 70000) begin
         step();
         cyc++;
      end
      chk("wd_done", 32'(done), 32'd1);
      chk("wd_err", 32'(err_code), 32'd3);
      chk("wd_hold", 32'(core_hold), 32'd1);
`else
      cyc = 0;
      while (cyc < 70000) begin
         step();
         cyc++;
      end
      chk("persist_busy", 32'(busy), 32'd1);
      chk("persist_err", 32'(err_code), 32'd0);
      chk("persist_hold", 32'(core_hold), 32'd0);
      // Reset mid-RUN
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_run_busy", 32'(busy), 32'd0);
      chk("rst_run_hold", 32'(core_hold), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chronospatial_run_ctrl.md
CHRONOSPATIAL_RUN_CTRL -- requirements
Module: chronospatial_run_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 12, the width of each A/B/C initial-value shadow register (multiple of 3).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the output FIFO depth (power of 2).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: cmd_valid  in  1  command byte valid; cmd_data  in  8  [7:5] opcode, [2:0] payload; cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-005 SHALL have ports: prog_wr_en  out  1  program write strobe; prog_wr_addr  out  4  program address; prog_wr_data  out  3  program word.
REQ-006 SHALL have ports: reg_load  out  1  one-cycle load strobe; reg_a_init, reg_b_init, reg_c_init  out  REG_W each  initial register values.
REQ-007 SHALL have ports: core_hold  out  1  high holds the core in reset/idle; core_halt  in  1  core halt; core_out_valid  in  1  core output strobe; core_reg_out  in  3  core output value.
REQ-008 SHALL have ports: out_valid  out  1; out_data  out  3; out_ready  in  1  output FIFO handshake; busy  out  1  state==RUN; done  out  1  state==DONE; err_code  out  2  sticky error.

Function
REQ-009 SHALL implement states IDLE, RUN, DONE; cmd_ready SHALL be 1 in every state.
REQ-010 Opcodes SHALL be: 000 NOP; 001 PROG; 010 REGA; 011 REGB; 100 REGC; 101 RUN; 110 CLEAR; 111 ABORT.
REQ-011 PROG accepted in cycle N in IDLE or DONE with prog_len<16 SHALL drive prog_wr_en=1, prog_wr_addr=prog_len, prog_wr_data=payload in cycle N+1, then increment prog_len (5-bit, saturates at 16).
REQ-012 PROG with prog_len==16 SHALL not write and SHALL raise err_code 1; the address SHALL never wrap.
REQ-013 REGA/REGB/REGC SHALL shift the selected shadow register left by 3 and insert the payload in bits [2:0], MSB-first; excess writes discard upper bits without error.
REQ-014 RUN accepted in cycle N in IDLE/DONE with prog_len>0 SHALL pulse reg_load in N+1, deassert core_hold in N+2, enter RUN in N+1, and flush the output FIFO.
REQ-015 RUN with prog_len==0 SHALL be ignored and raise err_code 1.
REQ-016 In RUN, any command other than NOP/ABORT SHALL be dropped and raise err_code 1.
REQ-017 ABORT in RUN SHALL assert core_hold the next cycle and go to IDLE; ABORT outside RUN SHALL act as NOP.
REQ-018 core_halt high in RUN SHALL assert core_hold the next cycle and go to DONE; core_halt outside RUN SHALL be ignored.
REQ-019 If ABORT acceptance and core_halt coincide, ABORT SHALL win (go to IDLE).
REQ-020 CLEAR outside RUN SHALL zero prog_len, shadow registers, FIFO and err_code, and go to IDLE.
REQ-021 core_out_valid in RUN SHALL push core_reg_out into the FIFO; if the FIFO is full and not popped that cycle, the value SHALL be dropped and raise err_code 2.
REQ-022 Simultaneous push and pop on a full FIFO SHALL succeed without error.
REQ-023 out_valid SHALL equal FIFO non-empty; a pop occurs on out_valid&out_ready; the FIFO SHALL remain drainable in DONE and IDLE.
REQ-024 err_code SHALL latch the first nonzero error and hold it until CLEAR or reset.

Reset
REQ-025 rst SHALL force state IDLE, core_hold=1, prog_len=0, all shadow registers 0, FIFO empty, err_code=0, and prog_wr_en, reg_load, out_valid, busy and done all 0.
REQ-026 rst mid-RUN SHALL take effect at the next clk edge, with core_hold=1 in the cycle after.

Configuration
REQ-027 With CHRONO_RUN_WATCHDOG_EN defined, a 16-bit cycle counter SHALL clear on RUN entry and increment in RUN; on reaching 65535 without core_halt, the block SHALL assert core_hold, go to DONE and raise err_code 3.
REQ-028 Without CHRONO_RUN_WATCHDOG_EN, no counter SHALL exist, RUN SHALL persist until core_halt, ABORT or rst, and err_code 3 SHALL never occur.

Verification
REQ-029 Load: PROG payloads 2,4,1,5 then REGA x4 payloads 1,2,3,4 -> prog writes at addresses 0..3 with data 2,4,1,5; reg_a_init=0x29C.
REQ-030 Overflow: 17 PROG commands -> 16 writes at addresses 0..15, no 17th write, err_code=1.
REQ-031 Run: RUN -> reg_load at N+1, core_hold=0 at N+2; inject outputs 3,7 then core_halt -> out_data 3 then 7, done=1, core_hold=1.
REQ-032 FIFO: out_ready=0, 5 core_out_valid pulses in RUN -> 4 values held, err_code=2; then core_out_valid together with a pop on a full FIFO -> no additional error.
REQ-033 Abort/edge cases: ABORT in the same cycle as core_halt -> IDLE, done=0; RUN with prog_len==0 -> stays IDLE, err_code=1.
REQ-034 Watchdog (macro defined): RUN with core_halt never asserted -> DONE and err_code=3 after 65535 cycles; with the macro undefined -> still busy after 70000 cycles.
